// File: rtl/dbg_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dbg_tx_arbiter
// Description : Round-robin packet arbiter sharing one byte-serial debug
//               transmitter among N sources; prefixes each packet with a
//               {HDR_TAG, channel} header byte.
// Revision    : 1.0 - initial release
// ============================================================================
module dbg_tx_arbiter #(
    parameter int         N       = 4,
    parameter int         HOLDOFF = 2,
    parameter logic [3:0] HDR_TAG = 4'hA
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req_valid,
    input  logic [8*N-1:0]   req_data,
    input  logic [N-1:0]     req_last,
    output logic [N-1:0]     req_ready,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             busy,
    output logic [3:0]       grant
);

    localparam int PTR_W = $clog2(N);
    localparam int CNT_W = $clog2(HOLDOFF);

    localparam logic [PTR_W-1:0] c_ptr_rst  = PTR_W'(N - 1);
    localparam logic [CNT_W-1:0] c_cnt_load = CNT_W'(HOLDOFF - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
    localparam logic [N-1:0]     c_one_hot  = N'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    state_t           r_state;
    state_t           r_ret;
    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] r_sel;
    logic [CNT_W-1:0] r_cnt;

    logic             w_any;
    logic [PTR_W-1:0] w_pick;
    logic             w_cur_valid;
    logic             w_cur_last;
    logic [7:0]       w_cur_data;
    logic             w_accept;

    // Winner is the requester at the smallest circular distance past r_ptr.
    always_comb begin
        int best_d;
        int d;
        best_d = N;
        d      = 0;
        w_pick = '0;
        w_any  = |req_valid;
        for (int j = 0; j < N; j++) begin
            if (req_valid[j]) begin
                d = j - int'(r_ptr) - 1;
                if (d < 0) begin
                    d = d + N;
                end
                if (d < best_d) begin
                    best_d = d;
                    w_pick = PTR_W'(j);
                end
            end
        end
    end

    always_comb begin
        w_cur_valid = 1'b0;
        w_cur_last  = 1'b0;
        w_cur_data  = 8'h00;
        for (int i = 0; i < N; i++) begin
            if (PTR_W'(i) == r_sel) begin
                w_cur_valid = req_valid[i];
                w_cur_last  = req_last[i];
                w_cur_data  = req_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        req_ready = '0;
        case (r_state)
            ST_HDR: begin
                tx_valid = 1'b1;
                tx_data  = {HDR_TAG, grant};
            end
            ST_DATA: begin
                tx_valid = w_cur_valid;
                tx_data  = w_cur_valid ? w_cur_data : 8'h00;
                if (w_cur_valid && tx_ready) begin
                    req_ready = c_one_hot << r_sel;
                end
            end
            default: ;
        endcase
    end

    assign w_accept = tx_valid && tx_ready;
    assign busy     = (r_state != ST_IDLE);
    assign grant    = 4'(r_sel);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ret   <= ST_IDLE;
            r_ptr   <= c_ptr_rst;
            r_sel   <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_sel   <= w_pick;
                        r_state <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (w_accept) begin
                        r_state <= ST_HOLD;
                        r_ret   <= ST_DATA;
                        r_cnt   <= c_cnt_load;
                    end
                end
                ST_DATA: begin
                    if (w_accept) begin
                        r_state <= ST_HOLD;
                        r_cnt   <= c_cnt_load;
                        if (w_cur_last) begin
                            r_ptr <= r_sel;
                            r_ret <= ST_IDLE;
                        end else begin
                            r_ret <= ST_DATA;
                        end
                    end
                end
                default: begin
                    // Leave when this decrement brings the counter to zero.
                    r_cnt <= r_cnt - c_cnt_one;
                    if (r_cnt <= c_cnt_one) begin
                        r_state <= r_ret;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire
